call_seq_ctrl: RTL and testbench

CALL_SEQ_CTRL -- requirements
Module: call_seq_ctrl

---
 rtl/pic_pkg.sv | 11 +
 rtl/ret_stack.sv | 56 +++++
 rtl/call_seq_ctrl.sv | 114 +++++++++++
 tb/tb_call_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared FSM state type and default interrupt vector for the call sequencer
package pic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [10:0] INT_VEC_DEFAULT = 11'h004;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - DEPTH x AW circular return-address LIFO with sticky overflow/underflow flags
module ret_stack #(
    parameter int AW    = 11,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;

    // ptr names the next free slot, so the newest entry sits one below it
    assign top = mem[ptr - PW'(1)];

    // Storage is deliberately left out of reset; only the pointer defines emptiness
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    // Pointer always wraps; the count saturates and the flags record the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count == CW'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else if (pop) begin
            ptr <= ptr - PW'(1);
            if (count == '0) begin
                unf <= 1'b1;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/call_seq_ctrl.sv
// rtl/call_seq_ctrl.sv - CALL/RETURN/interrupt PC sequencer; STACK_TRAP_EN redirects stack wraps to the reset vector
module call_seq_ctrl
    import pic_pkg::*;
#(
    parameter int            AW      = 11,
    parameter int            DEPTH   = 16,
    parameter logic [AW-1:0] INT_VEC = AW'(INT_VEC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     retfie,
    input  logic                     irq,
    input  logic [AW-1:0]            target,
    input  logic [AW-1:0]            pc_next,
    output logic                     pc_load,
    output logic [AW-1:0]            pc_load_val,
    output logic                     busy,
    output logic                     gie,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf,
    output logic                     unf
);

    state_t        state;
    logic          idle;
    logic          do_call;
    logic          do_ret;
    logic          do_retfie;
    logic          do_int;
    logic          push;
    logic          pop;
    logic [AW-1:0] top;

    // Fixed acceptance priority; reset blocks acceptance so no stale push lands in storage
    assign idle      = (state == IDLE) && !reset;
    assign do_call   = idle && call;
    assign do_ret    = idle && !call && ret;
    assign do_retfie = idle && !call && !ret && retfie;
    assign do_int    = idle && !call && !ret && !retfie && irq && gie;
    assign push      = do_call || do_int;
    assign pop       = do_ret || do_retfie;

`ifdef STACK_TRAP_EN
    logic trap;
    assign trap = (push && depth == ($clog2(DEPTH)+1)'(DEPTH)) ||
                  (pop && depth == '0);
`endif

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_next),
        .top   (top),
        .count (depth),
        .ovf   (ovf),
        .unf   (unf)
    );

    // Two-state sequencer: accept in IDLE, strobe the PC load for one EXEC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_load     <= 1'b0;
            busy        <= 1'b0;
            gie         <= 1'b0;
            pc_load_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push || pop) begin
                        state   <= EXEC;
                        pc_load <= 1'b1;
                        busy    <= 1'b1;
                        if (do_call) begin
                            pc_load_val <= target;
                        end else if (do_int) begin
                            pc_load_val <= INT_VEC;
                            gie         <= 1'b0;
                        end else begin
                            pc_load_val <= top;
                            if (do_retfie) begin
                                gie <= 1'b1;
                            end
                        end
`ifdef STACK_TRAP_EN
                        if (trap) begin
                            pc_load_val <= '0;
                            gie         <= 1'b0;
                        end
`endif
                    end
                end
                EXEC: begin
                    state   <= IDLE;
                    pc_load <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    pc_load <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_seq_ctrl.sv
// tb/tb_call_seq_ctrl.sv - scoreboard bench for the call/return/interrupt sequencer
module tb_call_seq_ctrl;

    localparam int AW    = 11;
    localparam int DEPTH = 16;
    localparam int DW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          retfie = 1'b0;
    logic          irq = 1'b0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] pc_next = '0;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic          busy;
    logic          gie;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;

    call_seq_ctrl #(
        .AW      (AW),
        .DEPTH   (DEPTH),
        .INT_VEC (11'h004)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .call        (call),
        .ret         (ret),
        .retfie      (retfie),
        .irq         (irq),
        .target      (target),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .busy        (busy),
        .gie         (gie),
        .depth       (depth),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_q [$];

    logic [AW-1:0] mem_m [DEPTH];
    int            ptr_m = 0;
    int            cnt_m = 0;
    logic          gie_m = 1'b0;
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;

    task automatic model_reset();
        ptr_m = 0;
        cnt_m = 0;
        gie_m = 1'b0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    // Drive one request at a negedge; predict, push expectation, then check EXEC and the following IDLE cycle
    task automatic cmd(input logic c, input logic r, input logic rf, input logic i,
                       input logic [AW-1:0] tgt, input logic [AW-1:0] pcn,
                       input logic exec_ret, input logic keep_irq);
        int            kind;
        logic          trap;
        logic [AW-1:0] v;
        call = c; ret = r; retfie = rf; irq = i; target = tgt; pc_next = pcn;
        kind = c ? 1 : r ? 3 : rf ? 4 : (i && gie_m) ? 2 : 0;
        trap = 1'b0;
        v    = '0;
        if (kind == 1 || kind == 2) begin
            trap = (cnt_m == DEPTH);
            mem_m[ptr_m] = pcn;
            ptr_m = (ptr_m + 1) % DEPTH;
            if (trap) ovf_m = 1'b1; else cnt_m++;
            v = (kind == 1) ? tgt : 11'h004;
            if (kind == 2) gie_m = 1'b0;
        end else if (kind >= 3) begin
            trap = (cnt_m == 0);
            ptr_m = (ptr_m + DEPTH - 1) % DEPTH;
            v = mem_m[ptr_m];
            if (trap) unf_m = 1'b1; else cnt_m--;
            if (kind == 4) gie_m = 1'b1;
        end
`ifdef STACK_TRAP_EN
        if (trap) begin
            v = '0;
            gie_m = 1'b0;
        end
`endif
        if (kind != 0) exp_q.push_back(v);
        @(negedge clk);
        call = 1'b0; ret = exec_ret; retfie = 1'b0;
        if (!keep_irq) irq = 1'b0;
        if (kind != 0) begin
            checks++;
            if (pc_load !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL exec_strobe: pc_load=%b busy=%b required 1/1", pc_load, busy);
            end
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                checks++;
                if (pc_load_val !== v) begin
                    errors++;
                    $display("FAIL pc_load_val: got %h required %h", pc_load_val, v);
                end
            end
        end else begin
            checks++;
            if (pc_load !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_accept: pc_load=%b busy=%b required 0/0", pc_load, busy);
            end
        end
        checks++;
        if (depth !== DW'(cnt_m)) begin
            errors++;
            $display("FAIL depth: got %0d required %0d", depth, cnt_m);
        end
        checks++;
        if (gie !== gie_m || ovf !== ovf_m || unf !== unf_m) begin
            errors++;
            $display("FAIL flags: gie/ovf/unf got %b%b%b required %b%b%b", gie, ovf, unf, gie_m, ovf_m, unf_m);
        end
        if (kind != 0) begin
            @(negedge clk);
            ret = 1'b0;
            checks++;
            if (pc_load !== 1'b0 || busy !== 1'b0 || depth !== DW'(cnt_m)) begin
                errors++;
                $display("FAIL idle_after_exec: pc_load=%b busy=%b depth=%0d required 0/0/%0d",
                         pc_load, busy, depth, cnt_m);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (pc_load !== 1'b0 || busy !== 1'b0 || gie !== 1'b0 || depth !== '0 ||
            ovf !== 1'b0 || unf !== 1'b0 || pc_load_val !== '0) begin
            errors++;
            $display("FAIL reset_state: pc_load=%b busy=%b gie=%b depth=%0d ovf=%b unf=%b val=%h required all zero",
                     pc_load, busy, gie, depth, ovf, unf, pc_load_val);
        end
    endtask

    task automatic test_call_ret();
        // A ret held during EXEC must be ignored (depth stays 1)
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 11'h123, 11'h010, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
    endtask

    task automatic test_irq();
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 11'h200, 11'h055, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 11'h077, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 11'h078, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        cmd(1'b1, 1'b0, 1'b0, 1'b1, 11'h300, 11'h0aa, 1'b0, 1'b1);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 11'h0ab, 1'b0, 1'b0);
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
    endtask

    task automatic test_overflow_underflow();
        test_reset();
        for (int k = 0; k < 17; k++) begin
            cmd(1'b1, 1'b0, 1'b0, 1'b0, 11'h100 + 11'(k), 11'h400 + 11'(k), 1'b0, 1'b0);
        end
        for (int k = 0; k < 17; k++) begin
            cmd(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 11'h3ff, 11'h111, 1'b0, 1'b0);
    endtask

    task automatic test_reset_exec();
        test_reset();
        call = 1'b1; target = 11'h2aa; pc_next = 11'h155;
        mem_m[ptr_m] = 11'h155;
        @(negedge clk);
        call = 1'b0;
        checks++;
        if (pc_load !== 1'b1) begin
            errors++;
            $display("FAIL reset_exec_pre: pc_load=%b required 1", pc_load);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (pc_load !== 1'b0 || busy !== 1'b0 || depth !== '0 || pc_load_val !== '0 || gie !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec: pc_load=%b busy=%b depth=%0d val=%h gie=%b required 0/0/0/000/0",
                     pc_load, busy, depth, pc_load_val, gie);
        end
        // Contents survive reset: an underflowing ret returns the slot below the empty pointer
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
        test_reset();
        test_call_ret();
        test_irq();
        test_priority();
        test_overflow_underflow();
        test_reset_exec();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
